// File: rtl/ccip_host_mem_responder_if.sv
// CCI-P request/response types and the requestor <-> host-memory bundle.
// The requestor drives the c0/c1 Tx structs; the responder drives the Rx struct.

typedef enum logic [1:0] {
  eCL_LEN_1 = 2'b00,
  eCL_LEN_2 = 2'b01,
  eCL_LEN_4 = 2'b11
} t_ccip_clLen;

typedef enum logic [3:0] {
  eREQ_RDLINE_I = 4'h0,
  eREQ_RDLINE_S = 4'h1
} t_ccip_c0_req;

typedef enum logic [3:0] {
  eREQ_WRLINE_I = 4'h0,
  eREQ_WRLINE_M = 4'h1,
  eREQ_WRPUSH_I = 4'h2,
  eREQ_WRFENCE  = 4'h4,
  eREQ_INTR     = 4'h6
} t_ccip_c1_req;

typedef enum logic [3:0] {
  eRSP_RDLINE = 4'h0,
  eRSP_UMSG   = 4'h4
} t_ccip_c0_rsp;

typedef enum logic [3:0] {
  eRSP_WRLINE  = 4'h0,
  eRSP_WRFENCE = 4'h4,
  eRSP_INTR    = 4'h6
} t_ccip_c1_rsp;

typedef struct packed {
  logic [1:0]   vc_sel;
  logic [1:0]   rsvd1;
  t_ccip_clLen  cl_len;
  t_ccip_c0_req req_type;
  logic [5:0]   rsvd0;
  logic [41:0]  address;
  logic [15:0]  mdata;
} t_ccip_c0_ReqMemHdr;

typedef struct packed {
  logic [5:0]   rsvd2;
  logic [1:0]   vc_sel;
  logic         sop;
  logic         rsvd1;
  t_ccip_clLen  cl_len;
  t_ccip_c1_req req_type;
  logic [5:0]   rsvd0;
  logic [41:0]  address;
  logic [15:0]  mdata;
} t_ccip_c1_ReqMemHdr;

typedef struct packed {
  logic [1:0]   vc_used;
  logic         rsvd1;
  logic         hit_miss;
  logic [1:0]   rsvd0;
  logic [1:0]   cl_num;
  t_ccip_c0_rsp resp_type;
  logic [15:0]  mdata;
} t_ccip_c0_RspMemHdr;

typedef struct packed {
  logic [1:0]   vc_used;
  logic         rsvd1;
  logic         hit_miss;
  logic         format;
  logic         rsvd0;
  logic [1:0]   cl_num;
  t_ccip_c1_rsp resp_type;
  logic [15:0]  mdata;
} t_ccip_c1_RspMemHdr;

typedef struct packed {
  t_ccip_c0_ReqMemHdr hdr;
  logic               valid;
} t_if_ccip_c0_Tx;

typedef struct packed {
  t_ccip_c1_ReqMemHdr hdr;
  logic [511:0]       data;
  logic               valid;
} t_if_ccip_c1_Tx;

typedef struct packed {
  t_ccip_c0_RspMemHdr hdr;
  logic [511:0]       data;
  logic               rspValid;
  logic               mmioRdValid;
  logic               mmioWrValid;
} t_if_ccip_c0_Rx;

typedef struct packed {
  t_ccip_c1_RspMemHdr hdr;
  logic               rspValid;
} t_if_ccip_c1_Rx;

typedef struct packed {
  logic           c0TxAlmFull;
  logic           c1TxAlmFull;
  t_if_ccip_c0_Rx c0;
  t_if_ccip_c1_Rx c1;
} t_if_ccip_Rx;

interface ccip_host_mem_responder_if;
  t_if_ccip_c0_Tx ccip_c0_tx;
  t_if_ccip_c1_Tx ccip_c1_tx;
  t_if_ccip_Rx    ccip_rx;

  modport master (output ccip_c0_tx, output ccip_c1_tx, input ccip_rx);
  modport slave  (input ccip_c0_tx, input ccip_c1_tx, output ccip_rx);
endinterface

// File: rtl/ccip_host_mem_responder.sv
// Host-memory model for CCI-P requestors: line store, delayed in-order reads, one-cycle writes.
// Latency: read beat 0 at accept+RD_LATENCY+1, write rsp next cycle; backpressure only via c0TxAlmFull, overflow drops.

module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_pop;

  assign pop_vld = (count != '0);
  assign pop_dat = store[rd_ptr];
  assign do_pop  = pop_rdy & pop_vld;

  always_ff @(posedge clk) begin
    if (push_vld) store[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push_vld} - {{PW{1'b0}}, do_pop};
    end
  end
endmodule

module ccip_host_mem_responder #(
  parameter int MEM_LINES  = 1024,
  parameter int RD_LATENCY = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ALMFULL_TH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  ccip_host_mem_responder_if.slave   bus,
  output logic                       err_ovf,
  output logic                       err_wrlen
);
  localparam int AW = $clog2(MEM_LINES);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_DEPTH);
  localparam logic [OW-1:0] TH_C    = OW'(ALMFULL_TH);

  typedef struct packed {
    logic [AW-1:0] line;
    logic [15:0]   mdata;
    logic [1:0]    len;
  } rd_req_t;
  localparam int RW = $bits(rd_req_t);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  logic [511:0]          mem [MEM_LINES];
  rd_req_t               dl_dat [RD_LATENCY];
  logic [RD_LATENCY-1:0] dl_vld;
  logic [OW-1:0]         occ;
  logic [OW-1:0]         occ_nxt;

  logic          rd_req_vld, rd_acc, wr_req_vld, wr_acc, wr_bad;
  logic          exit_vld, fifo_vld, fifo_push, head_vld, take;
  logic [RW-1:0] fifo_dat;
  rd_req_t       head;

  state_t        state;
  logic [1:0]    beat;
  logic [1:0]    last;
  logic [AW-1:0] cur_line;
  logic [15:0]   cur_mdata;

  logic          c0_vld;
  logic [15:0]   c0_mdata;
  logic [1:0]    c0_cl_num;
  logic [511:0]  c0_data;
  logic          c1_vld;
  logic [15:0]   c1_mdata;
  logic          almfull;
  t_if_ccip_Rx   rx;

  logic unused_bits;
  assign unused_bits = ^{bus.ccip_c0_tx, bus.ccip_c1_tx};

  assign rd_req_vld = bus.ccip_c0_tx.valid &
                      ((bus.ccip_c0_tx.hdr.req_type == eREQ_RDLINE_I) |
                       (bus.ccip_c0_tx.hdr.req_type == eREQ_RDLINE_S));
  assign rd_acc     = rd_req_vld & (occ != DEPTH_C);
  assign wr_req_vld = bus.ccip_c1_tx.valid &
                      ((bus.ccip_c1_tx.hdr.req_type == eREQ_WRLINE_I) |
                       (bus.ccip_c1_tx.hdr.req_type == eREQ_WRLINE_M));
  assign wr_acc     = wr_req_vld & (bus.ccip_c1_tx.hdr.cl_len == eCL_LEN_1);
  assign wr_bad     = wr_req_vld & (bus.ccip_c1_tx.hdr.cl_len != eCL_LEN_1);

  // The delay-line exit bypasses the FIFO only when the FIFO is empty, so order is kept
  // and an unloaded request reaches the output register right as it leaves the delay line.
  assign exit_vld  = dl_vld[RD_LATENCY-1];
  assign head      = fifo_vld ? rd_req_t'(fifo_dat) : dl_dat[RD_LATENCY-1];
  assign head_vld  = fifo_vld | exit_vld;
  assign take      = (state == S_IDLE) & head_vld;
  assign fifo_push = exit_vld & ~(take & ~fifo_vld);
  assign occ_nxt   = occ + OW'(rd_acc) - OW'(take);

  fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_pend_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (fifo_push),
    .push_dat (dl_dat[RD_LATENCY-1]),
    .pop_rdy  (take),
    .pop_vld  (fifo_vld),
    .pop_dat  (fifo_dat)
  );

  always_ff @(posedge clk) begin
    if (reset_n && wr_acc) mem[bus.ccip_c1_tx.hdr.address[AW-1:0]] <= bus.ccip_c1_tx.data;
  end

  always_ff @(posedge clk) begin
    dl_dat[0] <= {bus.ccip_c0_tx.hdr.address[AW-1:0], bus.ccip_c0_tx.hdr.mdata,
                  bus.ccip_c0_tx.hdr.cl_len};
    for (int i = 1; i < RD_LATENCY; i++) dl_dat[i] <= dl_dat[i-1];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dl_vld    <= '0;
      occ       <= '0;
      almfull   <= 1'b0;
      err_ovf   <= 1'b0;
      err_wrlen <= 1'b0;
      c1_vld    <= 1'b0;
      c1_mdata  <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) dl_vld[i] <= dl_vld[i-1];
      dl_vld[0] <= rd_acc;
      occ       <= occ_nxt;
      almfull   <= (DEPTH_C - occ_nxt) <= TH_C;
      if (rd_req_vld && !rd_acc) err_ovf <= 1'b1;
      if (wr_bad) err_wrlen <= 1'b1;
      c1_vld <= wr_acc;
      if (wr_acc) c1_mdata <= bus.ccip_c1_tx.hdr.mdata;
    end
  end

  // Memory is read with the pre-edge contents, so a same-edge write is not seen by this beat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      beat      <= '0;
      last      <= '0;
      cur_line  <= '0;
      cur_mdata <= '0;
      c0_vld    <= 1'b0;
      c0_mdata  <= '0;
      c0_cl_num <= '0;
      c0_data   <= '0;
    end else begin
      c0_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (head_vld) begin
            c0_vld    <= 1'b1;
            c0_mdata  <= head.mdata;
            c0_cl_num <= 2'd0;
            c0_data   <= mem[head.line];
            cur_line  <= head.line;
            cur_mdata <= head.mdata;
            last      <= head.len;
            beat      <= 2'd1;
            if (head.len != 2'd0) state <= S_BURST;
          end
        end
        S_BURST: begin
          c0_vld    <= 1'b1;
          c0_mdata  <= cur_mdata;
          c0_cl_num <= beat;
          c0_data   <= mem[cur_line + AW'(beat)];
          beat      <= beat + 2'd1;
          if (beat == last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rx                  = '0;
    rx.c0TxAlmFull      = almfull;
    rx.c0.rspValid      = c0_vld;
    rx.c0.hdr.resp_type = eRSP_RDLINE;
    rx.c0.hdr.mdata     = c0_mdata;
    rx.c0.hdr.cl_num    = c0_cl_num;
    rx.c0.data          = c0_data;
    rx.c1.rspValid      = c1_vld;
    rx.c1.hdr.resp_type = eRSP_WRLINE;
    rx.c1.hdr.mdata     = c1_mdata;
  end

  assign bus.ccip_rx = rx;
endmodule

// File: tb/tb_ccip_host_mem_responder.sv
// Directed bench for ccip_host_mem_responder: responses are captured on the falling edge
// with a cycle stamp and compared against hand-computed cycles, tags and line data.
module tb_ccip_host_mem_responder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic err_ovf, err_wrlen;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  ccip_host_mem_responder_if bus();

  ccip_host_mem_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .err_ovf   (err_ovf),
    .err_wrlen (err_wrlen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int           cyc;
    logic [15:0]  mdata;
    logic [1:0]   cl_num;
    logic [511:0] data;
    logic [3:0]   rtype;
    logic         fmt;
  } rsp_t;
  rsp_t c0q[$];
  rsp_t c1q[$];

  always @(negedge clk) begin
    rsp_t r;
    if (bus.ccip_rx.c0.rspValid === 1'b1) begin
      r.cyc = cyc; r.mdata = bus.ccip_rx.c0.hdr.mdata; r.cl_num = bus.ccip_rx.c0.hdr.cl_num;
      r.data = bus.ccip_rx.c0.data; r.rtype = bus.ccip_rx.c0.hdr.resp_type; r.fmt = 1'b0;
      c0q.push_back(r);
    end
    if (bus.ccip_rx.c1.rspValid === 1'b1) begin
      r.cyc = cyc; r.mdata = bus.ccip_rx.c1.hdr.mdata; r.cl_num = bus.ccip_rx.c1.hdr.cl_num;
      r.data = '0; r.rtype = bus.ccip_rx.c1.hdr.resp_type; r.fmt = bus.ccip_rx.c1.hdr.format;
      c1q.push_back(r);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    bus.ccip_c0_tx.valid = 1'b0;
    bus.ccip_c1_tx.valid = 1'b0;
  endtask

  task automatic set_rd(input logic [41:0] a, input logic [15:0] m, input t_ccip_clLen l);
    bus.ccip_c0_tx.hdr          = '0;
    bus.ccip_c0_tx.hdr.address  = a;
    bus.ccip_c0_tx.hdr.mdata    = m;
    bus.ccip_c0_tx.hdr.cl_len   = l;
    bus.ccip_c0_tx.hdr.req_type = eREQ_RDLINE_I;
    bus.ccip_c0_tx.valid        = 1'b1;
  endtask

  task automatic set_wr(input logic [41:0] a, input logic [511:0] d, input logic [15:0] m,
                        input t_ccip_clLen l, input t_ccip_c1_req t);
    bus.ccip_c1_tx.hdr          = '0;
    bus.ccip_c1_tx.hdr.address  = a;
    bus.ccip_c1_tx.hdr.mdata    = m;
    bus.ccip_c1_tx.hdr.cl_len   = l;
    bus.ccip_c1_tx.hdr.req_type = t;
    bus.ccip_c1_tx.hdr.sop      = 1'b1;
    bus.ccip_c1_tx.data         = d;
    bus.ccip_c1_tx.valid        = 1'b1;
  endtask

  task automatic wait_c0(input int n, input int budget);
    int k = 0;
    while (c0q.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (4) tick();
    tests++; if (bus.ccip_rx !== '0)
      begin fails++; $display("FAIL reset_rx: got %h want 0", bus.ccip_rx); end
    tests++; if (err_ovf !== 1'b0)
      begin fails++; $display("FAIL reset_err_ovf: got %b want 0", err_ovf); end
    tests++; if (err_wrlen !== 1'b0)
      begin fails++; $display("FAIL reset_err_wrlen: got %b want 0", err_wrlen); end
    tests++; if (bus.ccip_rx.c0TxAlmFull !== 1'b0)
      begin fails++; $display("FAIL reset_almfull: got %b want 0", bus.ccip_rx.c0TxAlmFull); end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_write_read();
    int t;
    c1q.delete(); t = cyc;
    set_wr(42'h10, {64{8'hA5}}, 16'h3, eCL_LEN_1, eREQ_WRLINE_I);
    tick();
    repeat (3) tick();
    tests++; if (c1q.size() != 1)
      begin fails++; $display("FAIL wr_rsp_count: got %0d want 1", c1q.size()); end
    else begin
      tests++; if (c1q[0].cyc != t + 1)
        begin fails++; $display("FAIL wr_rsp_cycle: got %0d want %0d", c1q[0].cyc, t + 1); end
      tests++; if (c1q[0].mdata !== 16'h3)
        begin fails++; $display("FAIL wr_rsp_mdata: got %h want 0003", c1q[0].mdata); end
      tests++; if ({c1q[0].rtype, c1q[0].fmt, c1q[0].cl_num} !== 7'd0)
        begin fails++; $display("FAIL wr_rsp_fields: got %h/%b/%h want 0/0/0",
                                c1q[0].rtype, c1q[0].fmt, c1q[0].cl_num); end
    end
    c0q.delete(); t = cyc;
    set_rd(42'h10, 16'h7, eCL_LEN_1);
    tick();
    wait_c0(1, 20);
    repeat (2) tick();
    tests++; if (c0q.size() != 1)
      begin fails++; $display("FAIL rd_rsp_count: got %0d want 1", c0q.size()); end
    else begin
      tests++; if (c0q[0].cyc != t + 9)
        begin fails++; $display("FAIL rd_latency: got cycle %0d want %0d", c0q[0].cyc, t + 9); end
      tests++; if (c0q[0].data !== {64{8'hA5}})
        begin fails++; $display("FAIL rd_data: got %h want a5..a5", c0q[0].data); end
      tests++; if ({c0q[0].mdata, c0q[0].cl_num, c0q[0].rtype} !== {16'h7, 2'd0, 4'd0})
        begin fails++; $display("FAIL rd_hdr: got mdata %h cl_num %0d type %h want 0007/0/0",
                                c0q[0].mdata, c0q[0].cl_num, c0q[0].rtype); end
    end
  endtask

  task automatic test_bad_write();
    c1q.delete();
    set_wr(42'h10, '0, 16'h4, eCL_LEN_2, eREQ_WRLINE_I);
    tick();
    set_wr(42'h11, '0, 16'h5, eCL_LEN_1, eREQ_WRFENCE);
    tick();
    repeat (4) tick();
    tests++; if (c1q.size() != 0)
      begin fails++; $display("FAIL bad_wr_no_rsp: got %0d rsps want 0", c1q.size()); end
    tests++; if (err_wrlen !== 1'b1)
      begin fails++; $display("FAIL err_wrlen_set: got %b want 1", err_wrlen); end
    c0q.delete();
    set_rd(42'h10, 16'h8, eCL_LEN_1);
    tick();
    wait_c0(1, 20);
    tests++; if (c0q.size() < 1 || c0q[0].data !== {64{8'hA5}})
      begin fails++; $display("FAIL bad_wr_dropped: got %0d rsps, data %h want a5..a5",
                              c0q.size(), c0q.size() > 0 ? c0q[0].data : '0); end
  endtask

  task automatic test_multi_line();
    int t;
    for (int i = 0; i < 4; i++) begin
      set_wr(42'h20 + 42'(i), 512'(i + 1), 16'h20 + 16'(i), eCL_LEN_1, eREQ_WRLINE_M);
      tick();
    end
    repeat (2) tick();
    c0q.delete(); t = cyc;
    set_rd(42'h20, 16'h55, eCL_LEN_4);
    tick();
    wait_c0(4, 30);
    repeat (2) tick();
    tests++; if (c0q.size() != 4)
      begin fails++; $display("FAIL ml_count: got %0d want 4", c0q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (c0q[i].cyc != t + 9 + i || c0q[i].cl_num !== 2'(i) ||
            c0q[i].data !== 512'(i + 1) || c0q[i].mdata !== 16'h55) begin
          fails++;
          $display("FAIL ml_beat%0d: got cyc %0d cl_num %0d data %0h mdata %h want %0d/%0d/%0d/0055",
                   i, c0q[i].cyc, c0q[i].cl_num, c0q[i].data, c0q[i].mdata, t + 9 + i, i, i + 1);
        end
      end
    end
  endtask

  // Three 4-line bursts hold the response side busy so 16 single reads reach full occupancy.
  task automatic test_flood();
    int t;
    logic [15:0] m;
    logic [1:0]  n;
    c0q.delete(); t = cyc;
    for (int c = 0; c < 20; c++) begin
      if (c == 13) begin
        tests++; if (bus.ccip_rx.c0TxAlmFull !== 1'b0)
          begin fails++; $display("FAIL almfull_free5: got %b want 0", bus.ccip_rx.c0TxAlmFull); end
      end
      if (c == 14) begin
        tests++; if (bus.ccip_rx.c0TxAlmFull !== 1'b1)
          begin fails++; $display("FAIL almfull_free4: got %b want 1", bus.ccip_rx.c0TxAlmFull); end
      end
      if (c == 19) begin
        tests++; if (err_ovf !== 1'b0)
          begin fails++; $display("FAIL ovf_early: got %b want 0", err_ovf); end
      end
      if (c < 3) set_rd(42'h20, 16'h80 + 16'(c), eCL_LEN_4);
      else       set_rd(42'h10, 16'(c - 3), eCL_LEN_1);
      tick();
    end
    tests++; if (err_ovf !== 1'b1)
      begin fails++; $display("FAIL ovf_set: got %b want 1", err_ovf); end
    wait_c0(28, 80);
    repeat (5) tick();
    tests++; if (c0q.size() != 28)
      begin fails++; $display("FAIL flood_count: got %0d want 28", c0q.size()); end
    else begin
      for (int k = 0; k < 28; k++) begin
        m = (k < 12) ? 16'h80 + 16'(k / 4) : 16'(k - 12);
        n = (k < 12) ? 2'(k % 4) : 2'd0;
        tests++;
        if (c0q[k].cyc != t + 9 + k || c0q[k].mdata !== m || c0q[k].cl_num !== n) begin
          fails++;
          $display("FAIL flood_rsp%0d: got cyc %0d mdata %h cl_num %0d want %0d/%h/%0d",
                   k, c0q[k].cyc, c0q[k].mdata, c0q[k].cl_num, t + 9 + k, m, n);
        end
      end
    end
    tests++; if (bus.ccip_rx.c0TxAlmFull !== 1'b0)
      begin fails++; $display("FAIL almfull_drained: got %b want 0", bus.ccip_rx.c0TxAlmFull); end
  endtask

  task automatic test_collision();
    int t;
    set_wr(42'h40, {64{8'h11}}, 16'h1, eCL_LEN_1, eREQ_WRLINE_I);
    tick();
    repeat (2) tick();
    c0q.delete(); t = cyc;
    set_rd(42'h40, 16'h9, eCL_LEN_1);
    tick();
    repeat (7) tick();
    set_wr(42'h40, {64{8'h22}}, 16'h2, eCL_LEN_1, eREQ_WRLINE_I);
    tick();
    wait_c0(1, 20);
    tests++; if (c0q.size() < 1 || c0q[0].cyc != t + 9 || c0q[0].data !== {64{8'h11}})
      begin fails++; $display("FAIL collide_old: got %0d rsps, data %h want 11..11 at %0d",
                              c0q.size(), c0q.size() > 0 ? c0q[0].data : '0, t + 9); end
    c0q.delete();
    set_rd(42'h40, 16'hA, eCL_LEN_1);
    tick();
    wait_c0(1, 20);
    tests++; if (c0q.size() < 1 || c0q[0].data !== {64{8'h22}})
      begin fails++; $display("FAIL collide_new: got %0d rsps, data %h want 22..22",
                              c0q.size(), c0q.size() > 0 ? c0q[0].data : '0); end
    c0q.delete();
    set_rd(42'h40, 16'hB, eCL_LEN_1);
    tick();
    repeat (6) tick();
    set_wr(42'h40, {64{8'h33}}, 16'h3, eCL_LEN_1, eREQ_WRLINE_I);
    tick();
    wait_c0(1, 20);
    tests++; if (c0q.size() < 1 || c0q[0].data !== {64{8'h33}})
      begin fails++; $display("FAIL write_before_beat: got %0d rsps, data %h want 33..33",
                              c0q.size(), c0q.size() > 0 ? c0q[0].data : '0); end
  endtask

  task automatic test_reset_midburst();
    c0q.delete();
    set_rd(42'h20, 16'h66, eCL_LEN_4);
    tick();
    repeat (9) tick();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    tests++; if (c0q.size() != 2)
      begin fails++; $display("FAIL midburst_beats: got %0d want 2", c0q.size()); end
    tests++; if (c0q.size() >= 2 && c0q[1].cl_num !== 2'd1)
      begin fails++; $display("FAIL midburst_last: got cl_num %0d want 1", c0q[1].cl_num); end
    tests++; if ({err_ovf, err_wrlen} !== 2'b00)
      begin fails++; $display("FAIL midburst_errs: got %b%b want 00", err_ovf, err_wrlen); end
    c0q.delete();
    set_rd(42'h20, 16'h77, eCL_LEN_4);
    tick();
    wait_c0(4, 30);
    for (int i = 0; i < 4; i++) begin
      tests++; if (c0q.size() <= i || c0q[i].data !== 512'(i + 1))
        begin fails++; $display("FAIL retained%0d: got %0d rsps, data %0h want %0d",
                                i, c0q.size(), c0q.size() > i ? c0q[i].data : '0, i + 1); end
    end
  endtask

  initial begin
    bus.ccip_c0_tx = '0;
    bus.ccip_c1_tx = '0;
    test_reset();
    test_write_read();
    test_bad_write();
    test_multi_line();
    test_flood();
    test_collision();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule
